// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - boot-loaded ROM window plus RAM responder for a byte-wide core
module mem_responder #(
    parameter logic [19:0] ROM_BASE  = 20'hFF000,
    parameter int          ROM_BYTES = 4096,
    parameter int          RAM_BYTES = 65536
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] address,
    input  logic [7:0]  data_w,
    input  logic        we,
    output logic [7:0]  data_r,
    input  logic [7:0]  ld_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    output logic        locked,
    output logic        fault
);
    localparam int                ROM_AW   = $clog2(ROM_BYTES);
    localparam int                RAM_AW   = $clog2(RAM_BYTES);
    localparam logic [20:0]       ROM_LO   = {1'b0, ROM_BASE};
    localparam logic [20:0]       ROM_HI   = ROM_LO + 21'(ROM_BYTES);
    localparam logic [20:0]       RAM_HI   = 21'(RAM_BYTES);
    localparam logic [ROM_AW-1:0] PTR_LAST = ROM_AW'(ROM_BYTES - 1);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] ptr_q, ptr_d;
    logic              ld_ready_q;
    logic              locked_q;
    logic [7:0]        data_r_q, data_r_d;
    logic              fault_q;

    logic [7:0] rom_q [ROM_BYTES];
    logic [7:0] ram_q [RAM_BYTES];

    logic [20:0]       addr_ext;
    logic              rom_hit, ram_hit, run, accept, ram_we, bad_we;
    logic [ROM_AW-1:0] rom_idx;
    logic [RAM_AW-1:0] ram_idx;

    // Decode on the full 20 bits so nothing above RAM_BYTES aliases into RAM.
    assign addr_ext = {1'b0, address};
    assign rom_hit  = (addr_ext >= ROM_LO) && (addr_ext < ROM_HI);
    assign ram_hit  = addr_ext < RAM_HI;
    assign rom_idx  = ROM_AW'(address - ROM_BASE);
    assign ram_idx  = address[RAM_AW-1:0];

    assign run    = (state_q == ST_RUN);
    assign accept = (state_q == ST_LOAD) && ld_valid && ld_ready_q;
    assign ram_we = run && we && ram_hit;
    assign bad_we = run && we && !ram_hit;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        data_r_d = 8'hFF;
        if (accept) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == PTR_LAST) begin
                state_d = ST_RUN;
            end
        end
        if (run) begin
            if (rom_hit) begin
                data_r_d = rom_q[rom_idx];
            end else if (ram_hit) begin
                data_r_d = ram_q[ram_idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            ptr_q      <= '0;
            ld_ready_q <= 1'b0;
            locked_q   <= 1'b0;
            data_r_q   <= 8'hFF;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ld_ready_q <= (state_d == ST_LOAD);
            locked_q   <= (state_d == ST_RUN);
            data_r_q   <= data_r_d;
            fault_q    <= bad_we;
        end
    end

    // Arrays are never cleared; contents survive reset.
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            rom_q[ptr_q] <= ld_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && ram_we) begin
            ram_q[ram_idx] <= data_w;
        end
    end

    assign data_r   = data_r_q;
    assign ld_ready = ld_ready_q;
    assign locked   = locked_q;
    assign fault    = fault_q;
endmodule
